// File: rtl/tlut_pkg.sv
// tlut_pkg: shared types for the tlut product accumulation stage
package tlut_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} drain_state_t;
endpackage

// File: rtl/DEF.sv
// DEF: shared tile-geometry constants for the tlut datapath
`ifndef DIM_A
`define DIM_A 2
`endif
`ifndef DIM_C
`define DIM_C 2
`endif
`ifndef DIM_B
`define DIM_B 3
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 8
`endif
`ifndef OUT_WIDTH
`define OUT_WIDTH (`ACC_WIDTH + $clog2(`DIM_B))
`endif

// File: rtl/drain_index_cnt.sv
// drain_index_cnt: row-major row/col wrap counter for draining a result tile
module drain_index_cnt #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int RW   = 1,
    parameter int CW   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_col_end;
    logic          w_row_end;
    assign w_col_end = r_col == CW'(COLS - 1);
    assign w_row_end = r_row == RW'(ROWS - 1);
    assign row  = r_row;
    assign col  = r_col;
    assign last = w_col_end & w_row_end;
    // step col inner, row outer, wrapping to (0,0) after the final element
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            r_col <= w_col_end ? '0 : r_col + 1'b1;
            r_row <= w_col_end ? (w_row_end ? '0 : r_row + 1'b1) : r_row;
        end
    end
endmodule

// File: rtl/tlut_prod_accum.sv
// tlut_prod_accum: sums DIM_B product windows per tile and drains via a double-buffered shadow bank
`ifndef DIM_A
`define DIM_A 2
`endif
`ifndef DIM_C
`define DIM_C 2
`endif
`ifndef DIM_B
`define DIM_B 3
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 8
`endif
module tlut_prod_accum
    import tlut_pkg::*;
#(
    parameter int DIM_A     = `DIM_A,
    parameter int DIM_C     = `DIM_C,
    parameter int DIM_B     = `DIM_B,
    parameter int ACC_WIDTH = `ACC_WIDTH,
    parameter int OUT_WIDTH = ACC_WIDTH + $clog2(DIM_B),
    localparam int RW = (DIM_C > 1) ? $clog2(DIM_C) : 1,
    localparam int CW = (DIM_A > 1) ? $clog2(DIM_A) : 1,
    localparam int BW = (DIM_B > 1) ? $clog2(DIM_B) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       clear,
    input  logic                                       win_done,
    input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] product_in,
    output logic                                       in_ready,
    output logic                                       overrun,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_WIDTH-1:0]                       out_data,
    output logic [RW-1:0]                              out_row,
    output logic [CW-1:0]                              out_col,
    output logic                                       out_last
);
    logic [DIM_C-1:0][DIM_A-1:0][OUT_WIDTH-1:0] r_acc;
    logic [DIM_C-1:0][DIM_A-1:0][OUT_WIDTH-1:0] r_shadow;
    logic [DIM_C-1:0][DIM_A-1:0][OUT_WIDTH-1:0] w_sum;
    logic [BW-1:0]  r_win_cnt;
    logic           r_hold;
    logic           r_overrun;
    drain_state_t   r_state;
    logic           w_fire;
    logic           w_last;
    logic           w_final;
    logic           w_shadow_free;
    logic           w_acc_en;
    logic           w_complete;
    logic           w_load;
    assign in_ready      = ~r_hold;
    assign overrun       = r_overrun;
    assign out_valid     = r_state == DRAIN;
    assign out_last      = out_valid & w_last;
    assign out_data      = r_shadow[out_row][out_col];
    assign w_fire        = out_valid & out_ready;
    assign w_final       = w_fire & w_last;
    assign w_shadow_free = (r_state == IDLE) | w_final;
    assign w_acc_en      = win_done & ~r_hold & ~clear;
    assign w_complete    = w_acc_en & (r_win_cnt == BW'(DIM_B - 1));
    assign w_load        = ~clear & w_shadow_free & (w_complete | r_hold);
    drain_index_cnt #(.ROWS(DIM_C), .COLS(DIM_A), .RW(RW), .CW(CW)) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (w_fire & ~clear),
        .row     (out_row),
        .col     (out_col),
        .last    (w_last)
    );
    // element-wise sum of the running accumulator and the zero-extended incoming window
    always_comb begin
        for (int c = 0; c < DIM_C; c++)
            for (int a = 0; a < DIM_A; a++)
                w_sum[c][a] = r_acc[c][a] + OUT_WIDTH'(product_in[c][a]);
    end
    // accumulate windows, hand finished tiles to the shadow bank, and sequence the drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_shadow  <= '0;
            r_win_cnt <= '0;
            r_hold    <= 1'b0;
            r_state   <= IDLE;
        end else if (clear) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_hold    <= 1'b0;
            r_state   <= IDLE;
        end else if (w_load) begin
            r_shadow  <= r_hold ? r_acc : w_sum;
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_hold    <= 1'b0;
            r_state   <= DRAIN;
        end else begin
            if (w_acc_en) r_acc <= w_sum;
            if (w_complete) r_hold <= 1'b1;
            else if (w_acc_en) r_win_cnt <= r_win_cnt + 1'b1;
            if (w_final) r_state <= IDLE;
        end
    end
    // flag a window that arrived while the stage was holding a finished tile
    always_ff @(posedge clk) begin
        if (!rst_n) r_overrun <= 1'b0;
        else r_overrun <= win_done & r_hold & ~clear;
    end
endmodule

// File: tb/tb_tlut_prod_accum.sv
// tb_tlut_prod_accum: directed self-checking bench for tlut_prod_accum
module tb_tlut_prod_accum;
    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      clear;
    logic                      win_done;
    logic [1:0][1:0][7:0]      product_in;
    logic                      in_ready;
    logic                      overrun;
    logic                      out_valid;
    logic                      out_ready;
    logic [9:0]                out_data;
    logic [0:0]                out_row;
    logic [0:0]                out_col;
    logic                      out_last;
    int total = 0;
    int fails = 0;

    tlut_prod_accum #(.DIM_A(2), .DIM_C(2), .DIM_B(3), .ACC_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .win_done   (win_done),
        .product_in (product_in),
        .in_ready   (in_ready),
        .overrun    (overrun),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_prod(input int v0, input int v1, input int v2, input int v3);
        product_in[0][0] = 8'(v0);
        product_in[0][1] = 8'(v1);
        product_in[1][0] = 8'(v2);
        product_in[1][1] = 8'(v3);
    endtask

    task automatic pulse();
        win_done = 1'b1;
        step();
        win_done = 1'b0;
    endtask

    task automatic chk_elem(input string tag, input int data, input int r, input int c, input int last);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".data"}, out_data, data);
        chk({tag, ".row"}, out_row, r);
        chk({tag, ".col"}, out_col, c);
        chk({tag, ".last"}, out_last, last);
    endtask

    task automatic drain4(input string tag, input int d0, input int d1, input int d2, input int d3);
        chk_elem({tag, "0"}, d0, 0, 0, 0); step();
        chk_elem({tag, "1"}, d1, 0, 1, 0); step();
        chk_elem({tag, "2"}, d2, 1, 0, 0); step();
        chk_elem({tag, "3"}, d3, 1, 1, 1); step();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; win_done = 1'b0; out_ready = 1'b0;
        set_prod(0, 0, 0, 0);
        step(); step();
        chk("rst.in_ready", in_ready, 1);
        chk("rst.overrun", overrun, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_row", out_row, 0);
        chk("rst.out_col", out_col, 0);
        chk("rst.out_last", out_last, 0);
        rst_n = 1'b1;
        step();

        // basic sum: 3 x 255 = 765 everywhere
        out_ready = 1'b1;
        set_prod(255, 255, 255, 255);
        pulse();
        chk("basic.valid_early", out_valid, 0);
        chk("basic.in_ready", in_ready, 1);
        pulse(); pulse();
        drain4("basic", 765, 765, 765, 765);
        chk("basic.idle", out_valid, 0);

        // distinct values with a 5-cycle stall on the first element
        out_ready = 1'b0;
        set_prod(1, 2, 3, 4);
        pulse(); pulse(); pulse();
        for (int i = 0; i < 5; i++) begin
            chk_elem("stall", 3, 0, 0, 0);
            step();
        end
        out_ready = 1'b1;
        drain4("distinct", 3, 6, 9, 12);
        chk("distinct.idle", out_valid, 0);

        // back-pressure: second tile completes while the first is stalled
        out_ready = 1'b0;
        set_prod(255, 255, 255, 255);
        pulse(); pulse(); pulse();
        set_prod(1, 2, 3, 4);
        pulse(); pulse();
        chk("bp.in_ready_before", in_ready, 1);
        pulse();
        chk("bp.in_ready_held", in_ready, 0);
        chk("bp.overrun_quiet", overrun, 0);
        set_prod(100, 100, 100, 100);
        pulse();
        chk("bp.overrun", overrun, 1);
        step();
        chk("bp.overrun_once", overrun, 0);
        out_ready = 1'b1;
        drain4("bp_a", 765, 765, 765, 765);
        chk("bp.in_ready_after", in_ready, 1);
        drain4("bp_b", 3, 6, 9, 12);
        chk("bp.idle", out_valid, 0);

        // back-to-back: final handshake coincides with completing window
        out_ready = 1'b0;
        set_prod(10, 10, 10, 10);
        pulse(); pulse(); pulse();
        set_prod(1, 2, 3, 4);
        pulse(); pulse();
        out_ready = 1'b1;
        step(); step(); step();
        chk_elem("b2b.t1last", 30, 1, 1, 1);
        pulse();
        chk("b2b.in_ready", in_ready, 1);
        drain4("b2b", 3, 6, 9, 12);
        chk("b2b.idle", out_valid, 0);

        // clear mid-tile discards partial sums
        set_prod(5, 5, 5, 5);
        pulse(); pulse();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr.in_ready", in_ready, 1);
        chk("clr.valid", out_valid, 0);
        set_prod(7, 7, 7, 7);
        pulse(); pulse(); pulse();
        drain4("clr", 21, 21, 21, 21);

        // reset in the middle of a drain
        pulse(); pulse(); pulse();
        step(); step();
        chk("rstm.row", out_row, 1);
        chk("rstm.col", out_col, 0);
        rst_n = 1'b0;
        step();
        chk("rstm.valid", out_valid, 0);
        chk("rstm.row0", out_row, 0);
        chk("rstm.col0", out_col, 0);
        chk("rstm.in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();
        chk("rstm.still_idle", out_valid, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
